// File: rtl/fdivsqrt_otfc4_iter_pkg.sv
// Shared definitions for the divide/square-root datapath: configuration record,
// controller state encoding and the one-hot digit bit positions.
package fdivsqrt_otfc4_iter_pkg;

    // Configuration record; only the fraction width is needed by the OTFC stage
    typedef struct packed {
        int DIVb;
    } cvw_t;

    // Controller states shared by the iteration blocks
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fdivsqrt_state_t;

    // One-hot udigit bit positions, also used by the F addend generator
    localparam int UDIG_P2 = 3;
    localparam int UDIG_P1 = 2;
    localparam int UDIG_M1 = 1;
    localparam int UDIG_M2 = 0;

endpackage

// File: rtl/fdivsqrt_otfc4_next.sv
// Combinational radix-4 on-the-fly conversion step: from C, U, UM and one
// signed digit, form the next position mask, result and decrement. OR-only.
module fdivsqrt_otfc4_next
    import fdivsqrt_otfc4_iter_pkg::*;
#(
    parameter int N = 12
) (
    input  logic [N-1:0] C,
    input  logic [N-1:0] U,
    input  logic [N-1:0] UM,
    input  logic [3:0]   udigit,
    output logic [N-1:0] cnext,
    output logic [N-1:0] unext,
    output logic [N-1:0] umnext
);

    logic [N-1:0] w;
    logic [N-1:0] wlo;
    logic [N-1:0] whi;

    // Mask grows by two ones; the newly set pair is the digit field
    assign cnext = {2'b11, C[N-1:2]};
    assign w     = cnext & ~C;
    // Low bit of the field is the lowest set bit of cnext: no carry needed
    assign wlo   = w & ~{cnext[N-2:0], 1'b0};
    assign whi   = w & ~wlo;

    // Digit decode with priority +2 > +1 > -1 > -2; U and UM are only ORed
    always_comb begin
        unext  = U;
        umnext = UM;
        if (udigit[UDIG_P2]) begin
            unext  = U | whi;
            umnext = U | wlo;
        end else if (udigit[UDIG_P1]) begin
            unext  = U | wlo;
            umnext = U;
        end else if (udigit[UDIG_M1]) begin
            unext  = UM | w;
            umnext = UM | whi;
        end else if (udigit[UDIG_M2]) begin
            unext  = UM | whi;
            umnext = UM | wlo;
        end else begin
            unext  = U;
            umnext = UM | w;
        end
    end

endmodule

// File: rtl/fdivsqrt_otfc4_iter.sv
// Radix-4 OTFC register stage with iteration counter and start/busy/done
// handshake for one divide or square-root operation.
module fdivsqrt_otfc4_iter
    import fdivsqrt_otfc4_iter_pkg::*;
#(
    parameter cvw_t P = '{DIVb: 8}
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                sqrt,
    input  logic [6:0]          niter,
    input  logic                kill,
    input  logic [3:0]          udigit,
    output logic [P.DIVb+3:0]   U,
    output logic [P.DIVb+3:0]   UM,
    output logic [P.DIVb+3:0]   C,
    output logic                busy,
    output logic                done,
    output logic [6:0]          itercnt
);

    localparam int         N    = P.DIVb + 4;
    localparam logic [6:0] NMAX = 7'(P.DIVb / 2);

    // Requested digit count clipped to what the fraction width can hold
    function automatic logic [6:0] sat_niter(input logic [6:0] n);
        return (n > NMAX) ? NMAX : n;
    endfunction

    fdivsqrt_state_t state_q, state_n;
    logic [6:0]      niter_q;
    logic            load, step;
    logic [N-1:0]    cnext, unext, umnext;
    logic [N-1:0]    cinit, usqrt;

    assign cinit = {4'b1111, {P.DIVb{1'b0}}};
    assign usqrt = {4'b0001, {P.DIVb{1'b0}}};

    fdivsqrt_otfc4_next #(.N(N)) u_next (
        .C      (C),
        .U      (U),
        .UM     (UM),
        .udigit (udigit),
        .cnext  (cnext),
        .unext  (unext),
        .umnext (umnext)
    );

    // Next-state decode; kill wins over everything, start only from IDLE/DONE
    always_comb begin
        state_n = state_q;
        load    = 1'b0;
        step    = 1'b0;
        if (kill) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        load    = 1'b1;
                        state_n = (sat_niter(niter) == 7'd0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    step = 1'b1;
                    if (itercnt + 7'd1 == niter_q) state_n = DONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State register with registered busy/done flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            busy    <= (state_n == BUSY);
            done    <= (state_n == DONE);
        end
    end

    // Result, decrement, mask and counter: load on start, update per digit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            U       <= '0;
            UM      <= '0;
            C       <= '0;
            itercnt <= '0;
            niter_q <= '0;
        end else if (load) begin
            C       <= cinit;
            U       <= sqrt ? usqrt : '0;
            UM      <= sqrt ? '0 : cinit;
            itercnt <= '0;
            niter_q <= sat_niter(niter);
        end else if (step) begin
            C       <= cnext;
            U       <= unext;
            UM      <= umnext;
            itercnt <= itercnt + 7'd1;
        end
    end

endmodule

// File: tb/tb_fdivsqrt_otfc4_iter.sv
// Self-checking bench for fdivsqrt_otfc4_iter with DIVb = 8 (N = 12).
module tb_fdivsqrt_otfc4_iter;
    import fdivsqrt_otfc4_iter_pkg::*;

    localparam logic [3:0] DP2 = 4'b1000;
    localparam logic [3:0] DP1 = 4'b0100;
    localparam logic [3:0] DZ  = 4'b0000;
    localparam logic [3:0] DM1 = 4'b0010;
    localparam logic [3:0] DM2 = 4'b0001;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        sqrt = 1'b0;
    logic [6:0]  niter = '0;
    logic        kill = 1'b0;
    logic [3:0]  udigit = '0;
    logic [11:0] U, UM, C;
    logic        busy, done;
    logic [6:0]  itercnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string           name;
        logic            sq;
        logic [6:0]      n;
        logic [3:0][3:0] dig;
        logic            hold;
        int              lat;
        logic [11:0]     eu;
        logic [11:0]     eum;
        logic [11:0]     ec;
        logic [6:0]      eit;
    } vec_t;

    vec_t vecs[8];
    vec_t sb_q[$];

    fdivsqrt_otfc4_iter #(.P(cvw_t'{DIVb: 8})) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .sqrt    (sqrt),
        .niter   (niter),
        .kill    (kill),
        .udigit  (udigit),
        .U       (U),
        .UM      (UM),
        .C       (C),
        .busy    (busy),
        .done    (done),
        .itercnt (itercnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one operation; expectation goes in the scoreboard, popped on done
    task automatic run_op(input vec_t v);
        int   cyc;
        int   k;
        logic seen;
        vec_t e;
        sb_q.push_back(v);
        @(negedge clk);
        start  = 1'b1;
        sqrt   = v.sq;
        niter  = v.n;
        udigit = DZ;
        cyc    = 0;
        k      = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (i == 0 && v.lat > 1) chk({v.name, ".busy"}, 32'(busy), 32'd1);
            start = v.hold;
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                udigit = (k < 4) ? v.dig[k] : DZ;
                k++;
            end
        end
        start = 1'b0;
        e = sb_q.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: done not seen within 20 cycles", e.name);
        end else begin
            chk({e.name, ".lat"}, 32'(cyc), 32'(e.lat));
            chk({e.name, ".U"}, 32'(U), 32'(e.eu));
            chk({e.name, ".UM"}, 32'(UM), 32'(e.eum));
            chk({e.name, ".C"}, 32'(C), 32'(e.ec));
            chk({e.name, ".itercnt"}, 32'(itercnt), 32'(e.eit));
        end
    endtask

    initial begin
        vecs[0] = '{"div_p2_m1", 1'b0, 7'd2,   {DZ, DZ, DM1, DP2},   1'b0, 3,
                    12'h070, 12'h060, 12'hFF0, 7'd2};
        vecs[1] = '{"sqrt_0",    1'b1, 7'd1,   {DZ, DZ, DZ, DZ},     1'b0, 2,
                    12'h100, 12'h0C0, 12'hFC0, 7'd1};
        vecs[2] = '{"div_m2",    1'b0, 7'd1,   {DZ, DZ, DZ, DM2},    1'b0, 2,
                    12'hF80, 12'hF40, 12'hFC0, 7'd1};
        vecs[3] = '{"div_n0",    1'b0, 7'd0,   {DZ, DZ, DZ, DZ},     1'b0, 1,
                    12'h000, 12'hF00, 12'hF00, 7'd0};
        vecs[4] = '{"div_n100",  1'b0, 7'd100, {DP1, DP1, DP1, DP1}, 1'b1, 5,
                    12'h055, 12'h054, 12'hFFF, 7'd4};
        vecs[5] = '{"sqrt_mix",  1'b1, 7'd4,   {DM2, DP2, DZ, DM1},  1'b0, 5,
                    12'h0C6, 12'h0C5, 12'hFFF, 7'd4};
        vecs[6] = '{"div_0011",  1'b0, 7'd1,   {DZ, DZ, DZ, 4'b0011}, 1'b0, 2,
                    12'hFC0, 12'hF80, 12'hFC0, 7'd1};
        vecs[7] = '{"div_0010",  1'b0, 7'd1,   {DZ, DZ, DZ, DM1},    1'b0, 2,
                    12'hFC0, 12'hF80, 12'hFC0, 7'd1};

        // Reset state
        #12;
        chk("rst.U", 32'(U), 32'h0);
        chk("rst.UM", 32'(UM), 32'h0);
        chk("rst.C", 32'(C), 32'h0);
        chk("rst.itercnt", 32'(itercnt), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // Kill in the 2nd busy cycle with a simultaneous start
        @(negedge clk);
        start = 1'b1; sqrt = 1'b0; niter = 7'd2; udigit = DZ;
        @(negedge clk);
        start = 1'b0; udigit = DP2;
        @(negedge clk);
        kill = 1'b1; start = 1'b1; sqrt = 1'b1; udigit = DM1;
        @(negedge clk);
        chk("kill.U", 32'(U), 32'h080);
        chk("kill.UM", 32'(UM), 32'h040);
        chk("kill.C", 32'(C), 32'hFC0);
        chk("kill.itercnt", 32'(itercnt), 32'd1);
        chk("kill.busy", 32'(busy), 32'd0);
        chk("kill.done", 32'(done), 32'd0);
        kill = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("kill.hold_U", 32'(U), 32'h080);
        chk("kill.hold_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of BUSY
        start = 1'b1; sqrt = 1'b0; niter = 7'd2; udigit = DZ;
        @(negedge clk);
        start = 1'b0; udigit = DP2;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst.U", 32'(U), 32'h0);
        chk("arst.UM", 32'(UM), 32'h0);
        chk("arst.C", 32'(C), 32'h0);
        chk("arst.itercnt", 32'(itercnt), 32'h0);
        chk("arst.busy", 32'(busy), 32'h0);
        chk("arst.done", 32'(done), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(vecs[6]);
        run_op(vecs[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
